// File: rtl/bram_frame_reader_if.sv
// ============================================================================
// Module      : bram_frame_reader_if
// Description : Command, BRAM read port and pixel stream bundle for the
//               frame reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_frame_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 12
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  line_len;
    logic [LEN_WIDTH-1:0]  num_lines;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_rdata;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_sof;
    logic                  m_eol;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, base_addr, line_len, num_lines, bram_rdata, m_ready,
        output bram_we, bram_addr, m_valid, m_data, m_sof, m_eol, busy, done
    );

    modport slave (
        output start, base_addr, line_len, num_lines, bram_rdata, m_ready,
        input  bram_we, bram_addr, m_valid, m_data, m_sof, m_eol, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/bram_frame_reader.sv
// ============================================================================
// Module      : bram_frame_reader
// Description : Walks a rectangular frame region out of a 1-cycle-latency
//               BRAM and streams it with SOF/EOL markers via a 3-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_frame_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 12
) (
    input  wire logic           clk,
    input  wire logic           rst,
    bram_frame_reader_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                  sof;
        logic                  eol;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_lines;
    logic [LEN_WIDTH-1:0]  r_col;
    logic [LEN_WIDTH-1:0]  r_line;
    logic [ADDR_WIDTH-1:0] r_line_base;
    logic [ADDR_WIDTH-1:0] r_addr;

    // r_req: address on the BRAM bus this cycle; r_rv: BRAM dout valid this cycle
    logic                  r_req;
    logic                  r_req_sof;
    logic                  r_req_eol;
    logic                  r_rv;
    logic                  r_rv_sof;
    logic                  r_rv_eol;

    entry_t                r_buf [3];
    logic [1:0]            r_count;

    logic                  w_pop;
    logic                  w_push;
    logic [1:0]            w_wr_idx;
    logic [2:0]            w_occ;
    logic                  w_room;
    logic                  w_issue;
    logic                  w_col_last;
    logic                  w_line_last;
    logic                  w_zero;

    assign w_pop       = (r_count != 2'd0) && bus.m_ready;
    assign w_push      = r_rv;
    assign w_wr_idx    = r_count - {1'b0, w_pop};
    // Both pipeline stages count as committed slots; a same-cycle pop frees one.
    assign w_occ       = {1'b0, r_count} + {2'b0, r_req} + {2'b0, r_rv};
    assign w_room      = w_occ < (3'd3 + {2'b0, w_pop});
    assign w_issue     = (r_state == S_RUN) && w_room;
    assign w_col_last  = (r_col == r_len - 1'b1);
    assign w_line_last = (r_line == r_lines - 1'b1);
    assign w_zero      = (bus.line_len == '0) || (bus.num_lines == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // Empty frames pass through DRAIN so the done pulse lands one cycle later.
            S_IDLE:  if (bus.start) w_state_nxt = w_zero ? S_DRAIN : S_RUN;
            S_RUN:   if (w_issue && w_col_last && w_line_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!r_req && !r_rv &&
                         ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop)))
                         w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_lines     <= '0;
            r_col       <= '0;
            r_line      <= '0;
            r_line_base <= '0;
            r_addr      <= '0;
            r_req       <= 1'b0;
            r_req_sof   <= 1'b0;
            r_req_eol   <= 1'b0;
            r_rv        <= 1'b0;
            r_rv_sof    <= 1'b0;
            r_rv_eol    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && bus.start) begin
                r_len       <= bus.line_len;
                r_lines     <= bus.num_lines;
                r_line_base <= bus.base_addr;
                r_col       <= '0;
                r_line      <= '0;
            end else if (w_issue) begin
                if (w_col_last) begin
                    r_col       <= '0;
                    r_line      <= r_line + 1'b1;
                    r_line_base <= r_line_base + ADDR_WIDTH'(r_len);
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            r_req <= w_issue;
            if (w_issue) begin
                r_addr    <= r_line_base + ADDR_WIDTH'(r_col);
                r_req_sof <= (r_line == '0) && (r_col == '0);
                r_req_eol <= w_col_last;
            end

            r_rv     <= r_req;
            r_rv_sof <= r_req_sof;
            r_rv_eol <= r_req_eol;
        end
    end

    // Shift-down buffer: entry 0 is always the head presented on the stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_buf[2] <= '0;
            r_count  <= 2'd0;
        end else begin
            if (w_pop) begin
                r_buf[0] <= r_buf[1];
                r_buf[1] <= r_buf[2];
            end
            if (w_push) begin
                r_buf[w_wr_idx] <= '{sof: r_rv_sof, eol: r_rv_eol, data: bus.bram_rdata};
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.bram_we   = 1'b0;
    assign bus.bram_addr = r_addr;
    assign bus.m_valid   = (r_count != 2'd0);
    assign bus.m_data    = r_buf[0].data;
    assign bus.m_sof     = r_buf[0].sof && (r_count != 2'd0);
    assign bus.m_eol     = r_buf[0].eol && (r_count != 2'd0);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);

endmodule

`default_nettype wire
